// File: rtl/gate_vector_sequencer.sv
// Stimulus sweep: steps vec through all 2^NIN codes, DWELL cycles each, with a latched ctrl word.
// Latency: the first vector appears on the edge that samples start; done rises on the edge after the last sample.
// Backpressure: none, the sweep free-runs once started; only abort or reset can stop it.
module gate_vector_sequencer #(
    parameter int NIN    = 9,
    parameter int CTRL_W = 8,
    parameter int DWELL  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic [NIN-1:0]    vec,
    output logic [CTRL_W-1:0] ctrl,
    output logic              sample,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);
    localparam logic [NIN-1:0] VEC_LAST   = {NIN{1'b1}};
    localparam logic [NIN-1:0] VEC_ONE    = {{(NIN-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [NIN-1:0]    vec_nxt;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic [7:0]        dwell, dwell_nxt;
    logic              start_ok;

    // abort outranks start in every state
    assign start_ok = start && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            vec   <= '0;
            ctrl  <= '0;
            dwell <= '0;
        end else begin
            state <= state_nxt;
            vec   <= vec_nxt;
            ctrl  <= ctrl_nxt;
            dwell <= dwell_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        vec_nxt   = vec;
        ctrl_nxt  = ctrl;
        dwell_nxt = dwell;
        sample    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_RUN;
                    ctrl_nxt  = ctrl_in;
                    vec_nxt   = '0;
                    dwell_nxt = '0;
                end
            end

            ST_RUN: begin
                sample = (dwell == DWELL_LAST);
                if (abort) begin
                    state_nxt = ST_IDLE;
                    vec_nxt   = '0;
                    dwell_nxt = '0;
                end else if (sample) begin
                    dwell_nxt = '0;
                    // last code stays on vec through DONE rather than wrapping
                    if (vec == VEC_LAST) begin
                        state_nxt = ST_DONE;
                    end else begin
                        vec_nxt = vec + VEC_ONE;
                    end
                end else begin
                    dwell_nxt = dwell + 8'd1;
                end
            end

            ST_DONE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    vec_nxt   = '0;
                    dwell_nxt = '0;
                end else if (start_ok) begin
                    state_nxt = ST_RUN;
                    ctrl_nxt  = ctrl_in;
                    vec_nxt   = '0;
                    dwell_nxt = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                vec_nxt   = '0;
                dwell_nxt = '0;
            end
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Bench for gate_vector_sequencer: two instances (9-bit/dwell 1 and 4-bit/dwell 3) against a cycle-count model.
module tb_gate_vector_sequencer;

    localparam int NA = 9, DA = 1, TA = (1 << NA) * DA;
    localparam int NB = 4, DB = 3, TB = (1 << NB) * DB;

    logic clk;
    logic rst_n;

    logic          start_a, abort_a, sample_a, busy_a, done_a;
    logic [7:0]    ctrl_in_a, ctrl_a;
    logic [NA-1:0] vec_a;

    logic          start_b, abort_b, sample_b, busy_b, done_b;
    logic [7:0]    ctrl_in_b, ctrl_b;
    logic [NB-1:0] vec_b;

    int n_checks = 0;
    int n_errs   = 0;

    gate_vector_sequencer #(.NIN(NA), .CTRL_W(8), .DWELL(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .ctrl_in(ctrl_in_a),
        .vec(vec_a), .ctrl(ctrl_a), .sample(sample_a), .busy(busy_a), .done(done_a)
    );

    gate_vector_sequencer #(.NIN(NB), .CTRL_W(8), .DWELL(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .ctrl_in(ctrl_in_b),
        .vec(vec_b), .ctrl(ctrl_b), .sample(sample_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 sweeping (n = cycles since the start edge), 2 finished.
    typedef struct {
        int mode;
        int n;
        int ctrl;
    } mdl_t;

    mdl_t ma = '{0, 0, 0};
    mdl_t mb = '{0, 0, 0};

    function automatic void mdl_step(inout mdl_t m, input logic st, input logic ab,
                                     input int ci, input int total);
        if (ab) begin
            m.mode = 0;
            m.n    = 0;
        end else if (st && m.mode != 1) begin
            m.mode = 1;
            m.n    = 0;
            m.ctrl = ci;
        end else if (m.mode == 1) begin
            m.n = m.n + 1;
            if (m.n == total) m.mode = 2;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma = '{0, 0, 0};
            mb = '{0, 0, 0};
        end else begin
            mdl_step(ma, start_a, abort_a, int'(ctrl_in_a), TA);
            mdl_step(mb, start_b, abort_b, int'(ctrl_in_b), TB);
        end
    end

    task automatic check_dut(input string p, input mdl_t m, input int d, input int total,
                             input logic [31:0] v, input logic [31:0] c, input logic [31:0] s,
                             input logic [31:0] b, input logic [31:0] dn);
        int ev;
        ev = (m.mode == 1) ? m.n / d : (m.mode == 2) ? total / d - 1 : 0;
        chk({p, "_vec"},    v,  32'(ev));
        chk({p, "_ctrl"},   c,  32'(m.ctrl));
        chk({p, "_sample"}, s,  32'((m.mode == 1) && (m.n % d == d - 1)));
        chk({p, "_busy"},   b,  32'(m.mode == 1));
        chk({p, "_done"},   dn, 32'(m.mode == 2));
    endtask

    always @(negedge clk) begin
        check_dut("a", ma, DA, TA, 32'(vec_a), 32'(ctrl_a), 32'(sample_a), 32'(busy_a), 32'(done_a));
        check_dut("b", mb, DB, TB, 32'(vec_b), 32'(ctrl_b), 32'(sample_b), 32'(busy_b), 32'(done_b));
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; ctrl_in_a = 8'h00;
        start_b = 1'b0; abort_b = 1'b0; ctrl_in_b = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_vec",    32'(vec_a),    32'd0);
        chk("rst_ctrl",   32'(ctrl_a),   32'd0);
        chk("rst_sample", 32'(sample_a), 32'd0);
        chk("rst_busy",   32'(busy_a),   32'd0);
        chk("rst_done",   32'(done_a),   32'd0);
        rst_n = 1'b1;

        // full 9-bit sweep, dwell 1, with stray starts and ctrl_in churn
        ctrl_in_a = 8'h0F;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < TA + 3; i++) begin
            if (sample_a) cnt++;
            if (i == 0)   chk("t1_first_vec", 32'(vec_a), 32'd0);
            if (i == 300) chk("t1_ctrl_hold", 32'(ctrl_a), 32'h0F);
            if (i == TA) begin
                chk("t1_done", 32'(done_a), 32'd1);
                chk("t1_busy", 32'(busy_a), 32'd0);
                chk("t1_vec",  32'(vec_a),  32'd511);
            end
            if (i < 500) begin
                start_a   = ($urandom_range(0, 7) == 0);
                ctrl_in_a = 8'($urandom);
            end else begin
                start_a = 1'b0;
            end
            if (i == 250) ctrl_in_a = 8'hF0;
            @(negedge clk);
        end
        chk("t1_samples", 32'(cnt), 32'd512);

        // 4-bit sweep, dwell 3
        ctrl_in_b = 8'h5A;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cnt = 0;
        for (int i = 0; i < TB + 4; i++) begin
            if (sample_b) cnt++;
            @(negedge clk);
        end
        chk("t2_samples", 32'(cnt),    32'd16);
        chk("t2_vec",     32'(vec_b),  32'd15);
        chk("t2_done",    32'(done_b), 32'd1);

        // start+abort together in DONE
        start_b = 1'b1; abort_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; abort_b = 1'b0;
        chk("t5_done_busy", 32'(busy_b), 32'd0);
        chk("t5_done_done", 32'(done_b), 32'd0);

        // abort at vec=100
        ctrl_in_a = 8'h33;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (100) @(negedge clk);
        chk("t3_vec_pre", 32'(vec_a), 32'd100);
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        chk("t3_vec",  32'(vec_a),  32'd0);
        chk("t3_busy", 32'(busy_a), 32'd0);
        chk("t3_done", 32'(done_a), 32'd0);
        chk("t3_ctrl", 32'(ctrl_a), 32'h33);
        cnt = 0;
        repeat (10) begin
            if (sample_a) cnt++;
            @(negedge clk);
        end
        chk("t3_no_sample", 32'(cnt), 32'd0);

        // start+abort together in IDLE
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        chk("t5_idle_busy", 32'(busy_a), 32'd0);

        // asynchronous reset between edges mid-sweep
        ctrl_in_a = 8'hA5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vec",    32'(vec_a),    32'd0);
        chk("t6_ctrl",   32'(ctrl_a),   32'd0);
        chk("t6_sample", 32'(sample_a), 32'd0);
        chk("t6_busy",   32'(busy_a),   32'd0);
        chk("t6_done",   32'(done_a),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ctrl_in_a = 8'h3C;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        for (int i = 0; i < TA + 3; i++) begin
            if (i == 0) chk("t6_restart_vec", 32'(vec_a), 32'd0);
            if (sample_a) cnt++;
            @(negedge clk);
        end
        chk("t6_samples", 32'(cnt),    32'd512);
        chk("t6_done2",   32'(done_a), 32'd1);

        // random start/abort/ctrl traffic on the short sweep
        for (int i = 0; i < 400; i++) begin
            start_b   = ($urandom_range(0, 19) == 0);
            abort_b   = ($urandom_range(0, 39) == 0);
            ctrl_in_b = 8'($urandom);
            @(negedge clk);
        end
        start_b = 1'b0;
        abort_b = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
